// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write arbiter and its users.
package regfile_pkg;

    typedef enum logic [1:0] {INIT, RUN, CLEAR} arb_state_t;

    localparam int REGFILE_WIDTH    = 32;
    localparam int REGFILE_NUM_REGS = 4;
    localparam int STAT_W           = 16;

    // Value each register reloads whenever its RESET is asserted.
    function automatic logic [REGFILE_WIDTH-1:0] reg_init(input int idx);
        return (idx == 1) ? 32'h0000_0018 : 32'h0000_0000;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer moves past whoever was last accepted.
module rr_arbiter2 (
    input  logic       CLK,
    input  logic       ASYNCRESET,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic rr_ptr;

    always_comb begin
        gnt = valid;
        if (valid == 2'b11) begin
            gnt         = 2'b00;
            gnt[rr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET)   rr_ptr <= 1'b0;
        else if (advance) rr_ptr <= gnt[0];
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two requesters onto one register-file write port and sequences RESET.
// Optional per-requester grant counters when REGFILE_ARB_STATS_EN is defined.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH    = REGFILE_WIDTH,
    parameter int NUM_REGS = REGFILE_NUM_REGS,
    parameter int AW       = 2
) (
    input  logic                CLK,
    input  logic                ASYNCRESET,
    input  logic                req0_valid,
    input  logic [AW-1:0]       req0_addr,
    input  logic [WIDTH-1:0]    req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [AW-1:0]       req1_addr,
    input  logic [WIDTH-1:0]    req1_data,
    output logic                req1_ready,
    input  logic                clear_req,
    output logic [NUM_REGS-1:0] rf_ce,
    output logic [WIDTH-1:0]    rf_wdata,
    output logic                rf_reset,
    output logic                init_done,
    output logic                addr_err
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]   gnt_cnt0,
    output logic [STAT_W-1:0]   gnt_cnt1
`endif
);

    arb_state_t          state;
    logic                rst_q;
    logic                run, clr_now, hs;
    logic [1:0]          gnt, ready;
    logic [AW-1:0]       win_addr;
    logic [WIDTH-1:0]    win_data;
    logic [NUM_REGS-1:0] ce_nxt;

    assign run      = (state == RUN);
    assign clr_now  = run & clear_req;
    assign ready    = gnt & {2{run & ~clear_req}};
    assign hs       = |ready;
    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign win_addr = ready[1] ? req1_addr : req0_addr;
    assign win_data = ready[1] ? req1_data : req0_data;

    // RESET follows clear_req immediately so a write issued in that same cycle loses.
    assign rf_reset = rst_q | clr_now;

    rr_arbiter2 u_arb (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .valid      ({req1_valid, req0_valid}),
        .advance    (hs),
        .gnt        (gnt)
    );

    always_comb begin
        ce_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (win_addr == AW'(i)) ce_nxt[i] = hs;
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state     <= INIT;
            rst_q     <= 1'b1;
            init_done <= 1'b0;
            rf_ce     <= '0;
            rf_wdata  <= '0;
            addr_err  <= 1'b0;
        end else begin
            rf_ce    <= ce_nxt;
            addr_err <= hs & ~(|ce_nxt);
            if (hs) rf_wdata <= win_data;
            case (state)
                INIT: begin
                    state     <= RUN;
                    rst_q     <= 1'b0;
                    init_done <= 1'b1;
                end
                RUN: if (clear_req) begin
                    state <= CLEAR;
                    rst_q <= 1'b1;
                end
                CLEAR: begin
                    state <= RUN;
                    rst_q <= 1'b0;
                end
                default: begin
                    state <= INIT;
                    rst_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (clr_now) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (ready[0] && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
            if (ready[1] && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter (4- and 3-register builds).
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int W = REGFILE_WIDTH;

    logic          CLK = 1'b0;
    logic          ASYNCRESET;
    logic          req0_valid, req1_valid, clear_req;
    logic [1:0]    req0_addr, req1_addr;
    logic [W-1:0]  req0_data, req1_data;
    logic          req0_ready, req1_ready, rf_reset, init_done, addr_err;
    logic [3:0]    rf_ce;
    logic [W-1:0]  rf_wdata;
    logic          r0_ready3, r1_ready3, rf_reset3, init_done3, addr_err3;
    logic [2:0]    rf_ce3;
    logic [W-1:0]  rf_wdata3;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0]   gnt_cnt0, gnt_cnt1, gnt_cnt0_3, gnt_cnt1_3;
`endif

    always #5 CLK = ~CLK;

    regfile_write_arbiter #(.WIDTH(W), .NUM_REGS(4), .AW(2)) u_dut (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .clear_req(clear_req), .rf_ce(rf_ce), .rf_wdata(rf_wdata), .rf_reset(rf_reset),
        .init_done(init_done), .addr_err(addr_err)
`ifdef REGFILE_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
    );

    regfile_write_arbiter #(.WIDTH(W), .NUM_REGS(3), .AW(2)) u_dut3 (
        .CLK(CLK), .ASYNCRESET(ASYNCRESET),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(r0_ready3),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(r1_ready3),
        .clear_req(clear_req), .rf_ce(rf_ce3), .rf_wdata(rf_wdata3), .rf_reset(rf_reset3),
        .init_done(init_done3), .addr_err(addr_err3)
`ifdef REGFILE_ARB_STATS_EN
        , .gnt_cnt0(gnt_cnt0_3), .gnt_cnt1(gnt_cnt1_3)
`endif
    );

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: phase 0=init 1=run 2=clear; ptr = preferred requester.
    int           m_phase, m_ptr, m_cnt0, m_cnt1;
    bit           m_done, m_wvalid, m_err3, hs0, hs1;
    logic [3:0]   m_ce;
    logic [2:0]   m_ce3;
    logic [W-1:0] m_wdata;
    logic [W-1:0] regs [4];
    logic         o_rst, o_rdy0, o_rdy1, o_err3, o_done;
    logic [3:0]   o_ce;
    logic [2:0]   o_ce3;
    logic [W-1:0] o_wdata;

    task automatic cycle();
        bit g0, g1, en, exp_rst;
        logic [1:0] a;
        @(negedge CLK);
        en = (m_phase == 1) && !clear_req;
        if (req0_valid && req1_valid) begin
            g0 = (m_ptr == 0);
            g1 = !g0;
        end else begin
            g0 = req0_valid;
            g1 = req1_valid;
        end
        hs0 = g0 && en;
        hs1 = g1 && en;
        exp_rst = (m_phase != 1) || clear_req;
        o_rst = rf_reset; o_rdy0 = req0_ready; o_rdy1 = req1_ready; o_ce = rf_ce;
        o_ce3 = rf_ce3; o_err3 = addr_err3; o_wdata = rf_wdata; o_done = init_done;
        chk("ready0", req0_ready, hs0);
        chk("ready1", req1_ready, hs1);
        chk("ready0_n3", r0_ready3, hs0);
        chk("ready1_n3", r1_ready3, hs1);
        chk("rf_ce", rf_ce, m_ce);
        chk("rf_ce_n3", rf_ce3, m_ce3);
        chk("addr_err", addr_err, 0);
        chk("addr_err_n3", addr_err3, m_err3);
        chk("rf_reset", rf_reset, exp_rst);
        chk("rf_reset_n3", rf_reset3, exp_rst);
        chk("init_done", init_done, m_done);
        chk("init_done_n3", init_done3, m_done);
        if (m_wvalid) begin
            chk("rf_wdata", rf_wdata, m_wdata);
            chk("rf_wdata_n3", rf_wdata3, m_wdata);
        end
`ifdef REGFILE_ARB_STATS_EN
        chk("gnt_cnt0", gnt_cnt0, m_cnt0);
        chk("gnt_cnt1", gnt_cnt1, m_cnt1);
`endif
        // Register file fed by the arbiter: RESET has priority over CE.
        for (int i = 0; i < 4; i++)
            if (rf_reset) regs[i] = reg_init(i);
            else if (rf_ce[i]) regs[i] = rf_wdata;
        m_ce = '0; m_ce3 = '0; m_err3 = 0;
        m_wvalid = hs0 || hs1;
        if (m_wvalid) begin
            a = hs1 ? req1_addr : req0_addr;
            m_wdata = hs1 ? req1_data : req0_data;
            m_ce[a] = 1'b1;
            if (a < 3) m_ce3[a] = 1'b1;
            else m_err3 = 1;
        end
        if (hs0) m_ptr = 1;
        else if (hs1) m_ptr = 0;
        if (hs0 && m_cnt0 < 65535) m_cnt0++;
        if (hs1 && m_cnt1 < 65535) m_cnt1++;
        case (m_phase)
            0: begin m_phase = 1; m_done = 1; end
            1: if (clear_req) begin m_phase = 2; m_cnt0 = 0; m_cnt1 = 0; end
            default: m_phase = 1;
        endcase
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESET = 1'b1;
        clear_req = 0; req0_valid = 0; req1_valid = 0;
        #2;
        chk("rst_ce", rf_ce, 0);
        chk("rst_rf_reset", rf_reset, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_addr_err", addr_err3, 0);
        chk("rst_wdata", rf_wdata, 0);
        @(posedge CLK);
        #1;
        ASYNCRESET = 1'b0;
        m_phase = 0; m_ptr = 0; m_done = 0; m_wvalid = 0; m_err3 = 0;
        m_ce = '0; m_ce3 = '0; m_cnt0 = 0; m_cnt1 = 0; hs0 = 0; hs1 = 0;
        for (int i = 0; i < 4; i++) regs[i] = reg_init(i);
    endtask

    initial begin
        int n0, n1;
        req0_addr = 0; req1_addr = 0; req0_data = 0; req1_data = 0;
        do_reset();

        // Init sequence
        cycle();
        chk("t1_init_rst", o_rst, 1);
        cycle();
        chk("t1_run_rst", o_rst, 0);
        chk("t1_done", o_done, 1);
        chk("t1_ce", o_ce, 0);
        chk("t1_reg0", regs[0], 32'h0);
        chk("t1_reg1", regs[1], 32'h18);

        // Single write from requester 0
        req0_valid = 1; req0_addr = 1; req0_data = 32'hDEADBEEF;
        cycle();
        chk("t2_ready", o_rdy0, 1);
        req0_valid = 0;
        cycle();
        chk("t2_ce", o_ce, 4'b0010);
        chk("t2_wdata", o_wdata, 32'hDEADBEEF);
        cycle();
        chk("t2_reg1", regs[1], 32'hDEADBEEF);

        // Contention from reset: 0,1,0,1
        do_reset();
        cycle();
        req0_valid = 1; req0_addr = 0; req0_data = 32'h100;
        req1_valid = 1; req1_addr = 1; req1_data = 32'h200;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_order", {o_rdy1, o_rdy0}, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) chk("t3_ce", o_ce, (k % 2) ? 4'b0001 << (k - 1) : 4'b0001 << (k - 1));
            if (hs0) begin
                if (k >= 2) req0_valid = 0;
                else begin req0_addr = 2; req0_data = 32'h101; end
            end
            if (hs1) begin
                if (k >= 2) req1_valid = 0;
                else begin req1_addr = 3; req1_data = 32'h201; end
            end
        end
        cycle();
        chk("t3_last_ce", o_ce, 4'b1000);

        // Write then clear: the clear wins
        req0_valid = 1; req0_addr = 0; req0_data = 32'h1234;
        req1_valid = 1; req1_addr = 2; req1_data = 32'h55;
        cycle();
        chk("t4_ready0", o_rdy0, 1);
        req0_valid = 0; clear_req = 1;
        cycle();
        chk("t4_ce", o_ce, 4'b0001);
        chk("t4_rst", o_rst, 1);
        chk("t4_rdy_clr", {o_rdy1, o_rdy0}, 2'b00);
        clear_req = 0;
        cycle();
        chk("t4_rst_clear", o_rst, 1);
        chk("t4_rdy_clear", {o_rdy1, o_rdy0}, 2'b00);
        chk("t4_reg0", regs[0], 32'h0);
        cycle();
        chk("t4_ready1", o_rdy1, 1);
        req1_valid = 0;
        cycle();

        // Out-of-range on the 3-register build
        req0_valid = 1; req0_addr = 3; req0_data = 32'hA5A5A5A5;
        cycle();
        chk("t5_ready", o_rdy0, 1);
        req0_valid = 0;
        cycle();
        chk("t5_ce3", o_ce3, 3'b000);
        chk("t5_err", o_err3, 1);
        cycle();
        chk("t5_err_pulse", o_err3, 0);

`ifdef REGFILE_ARB_STATS_EN
        do_reset();
        cycle();
        n0 = 5; n1 = 3;
        for (int c = 0; c < 40 && (n0 + n1) > 0; c++) begin
            req0_valid = (n0 > 0); req0_addr = 2'(c); req0_data = $urandom;
            req1_valid = (n1 > 0); req1_addr = 2'(c + 1); req1_data = $urandom;
            cycle();
            if (hs0) n0--;
            if (hs1) n1--;
        end
        req0_valid = 0; req1_valid = 0;
        chk("t6_budget", n0 + n1, 0);
        @(negedge CLK);
        chk("t6_cnt0", gnt_cnt0, 5);
        chk("t6_cnt1", gnt_cnt1, 3);
        @(posedge CLK); #1;
        m_wvalid = 0; m_ce = '0; m_ce3 = '0; m_err3 = 0;
        clear_req = 1;
        cycle();
        clear_req = 0;
        cycle();
        chk("t6_cnt0_clr", gnt_cnt0, 0);
        chk("t6_cnt1_clr", gnt_cnt1, 0);
`else
        n0 = 0; n1 = 0;
`endif

        // Random traffic with occasional clears and resets
        for (int c = 0; c < 800; c++) begin
            if (!req0_valid || hs0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_addr  = 2'($urandom_range(0, 3));
                req0_data  = $urandom;
            end
            if (!req1_valid || hs1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_addr  = 2'($urandom_range(0, 3));
                req1_data  = $urandom;
            end
            clear_req = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
